alu_ctrl_md: RTL and testbench

- Next-generation ALU control for the MIPS datapath.
- Decodes ALUOp/funct into ALU control, including xor, nor and sltu.
- Sequences the multi-cycle mult/multu/div/divu unit, with a latency counter and a stall output for the hazard-detection logic.
- Sits in the EX stage between the main decoder/ID-EX register and both the ALU and the HI/LO multiply-divide unit.

---
 rtl/alu_ctrl_md.sv | 128 ++++++++++++
 tb/tb_alu_ctrl_md.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_md.sv
// ============================================================================
// Module  : alu_ctrl_md
// Purpose : EX-stage ALU control decode plus mult/div sequencing and stall.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl_md #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  input  logic       i_ex_valid,
  input  logic       i_flush,
  output logic [3:0] o_alu_ctrl,
  output logic       o_jr,
  output logic [1:0] o_hilo_rd,
  output logic       o_md_start,
  output logic       o_md_is_div,
  output logic       o_md_signed,
  output logic       o_md_busy,
  output logic       o_hilo_we,
  output logic       o_stall
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_mul_cnt = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] c_div_cnt = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_start;
  logic             r_md_is_div;
  logic             r_md_signed;

  logic w_is_md;
  logic w_accept;
  logic w_busy;

  always_comb begin
    o_alu_ctrl = 4'b0000;
    o_jr       = 1'b0;
    o_hilo_rd  = 2'b00;
    w_is_md    = 1'b0;
    case (i_alu_op)
      2'b00: o_alu_ctrl = 4'b0010;
      2'b01: o_alu_ctrl = 4'b0110;
      2'b11: o_alu_ctrl = 4'b0000;
      default: begin
        case (i_funct)
          6'b100000, 6'b100001: o_alu_ctrl = 4'b0010;
          6'b100010, 6'b100011: o_alu_ctrl = 4'b0110;
          6'b100100: o_alu_ctrl = 4'b0000;
          6'b100101: o_alu_ctrl = 4'b0001;
          6'b100110: o_alu_ctrl = 4'b0011;
          6'b100111: o_alu_ctrl = 4'b1100;
          6'b101010: o_alu_ctrl = 4'b0111;
          6'b101011: o_alu_ctrl = 4'b1000;
          // jr routes rs through the ALU unchanged via or with $zero
          6'b001000: begin
            o_alu_ctrl = 4'b0001;
            o_jr       = 1'b1;
          end
          6'b010000: o_hilo_rd = 2'b01;
          6'b010010: o_hilo_rd = 2'b10;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: w_is_md = 1'b1;
          default: o_alu_ctrl = 4'b0000;
        endcase
      end
    endcase
  end

  assign w_busy   = (r_state == S_BUSY);
  assign w_accept = (r_state == S_IDLE) & i_ex_valid & w_is_md & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_md_start  <= 1'b0;
      r_md_is_div <= 1'b0;
      r_md_signed <= 1'b0;
    end else begin
      r_md_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_BUSY;
            r_cnt       <= i_funct[1] ? c_div_cnt : c_mul_cnt;
            r_md_start  <= 1'b1;
            r_md_is_div <= i_funct[1];
            r_md_signed <= ~i_funct[0];
          end
        end
        default: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
      endcase
    end
  end

  assign o_md_start  = r_md_start;
  assign o_md_is_div = r_md_is_div;
  assign o_md_signed = r_md_signed;
  assign o_md_busy   = w_busy;
  assign o_hilo_we   = w_busy & (r_cnt == '0) & ~i_flush;
  // Dependent mfhi/mflo and any md op wait out the whole operation, hilo_we cycle included
  assign o_stall     = w_busy & i_ex_valid & ~i_flush & (w_is_md | (o_hilo_rd != 2'b00));

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_md.sv
// ============================================================================
// Module  : tb_alu_ctrl_md
// Purpose : Self-checking bench: decode table plus scoreboarded mult/div sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_ctrl_md;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] i_alu_op;
  logic [5:0] i_funct;
  logic       i_ex_valid;
  logic       i_flush;
  logic [3:0] o_alu_ctrl;
  logic       o_jr;
  logic [1:0] o_hilo_rd;
  logic       o_md_start;
  logic       o_md_is_div;
  logic       o_md_signed;
  logic       o_md_busy;
  logic       o_hilo_we;
  logic       o_stall;

  alu_ctrl_md #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_alu_op   (i_alu_op),
    .i_funct    (i_funct),
    .i_ex_valid (i_ex_valid),
    .i_flush    (i_flush),
    .o_alu_ctrl (o_alu_ctrl),
    .o_jr       (o_jr),
    .o_hilo_rd  (o_hilo_rd),
    .o_md_start (o_md_start),
    .o_md_is_div(o_md_is_div),
    .o_md_signed(o_md_signed),
    .o_md_busy  (o_md_busy),
    .o_hilo_we  (o_hilo_we),
    .o_stall    (o_stall)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
    logic       jr;
    logic [1:0] hrd;
  } dec_t;

  typedef struct packed {
    logic [31:0] c;
    logic        is_div;
    logic        sgn;
  } start_t;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int hq[$];
  start_t sq[$];
  dec_t dec[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: md_start and hilo_we must match the queued expectations in order
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_md_start) begin
        if (sq.size() == 0) chk("unexpected_md_start", 64'(cyc), 64'hFFFF);
        else chk("md_start_sb", {30'd0, cyc[31:0], o_md_is_div, o_md_signed}, {30'd0, sq.pop_front()});
      end
      if (o_hilo_we) begin
        if (hq.size() == 0) chk("unexpected_hilo_we", 64'(cyc), 64'hFFFF);
        else chk("hilo_we_sb", 64'(cyc), 64'(hq.pop_front()));
      end
    end
  end

  initial begin
    dec[0]  = '{2'b10, 6'b100000, 4'b0010, 1'b0, 2'b00};
    dec[1]  = '{2'b10, 6'b100010, 4'b0110, 1'b0, 2'b00};
    dec[2]  = '{2'b10, 6'b100100, 4'b0000, 1'b0, 2'b00};
    dec[3]  = '{2'b10, 6'b100101, 4'b0001, 1'b0, 2'b00};
    dec[4]  = '{2'b10, 6'b100110, 4'b0011, 1'b0, 2'b00};
    dec[5]  = '{2'b10, 6'b100111, 4'b1100, 1'b0, 2'b00};
    dec[6]  = '{2'b10, 6'b101010, 4'b0111, 1'b0, 2'b00};
    dec[7]  = '{2'b10, 6'b101011, 4'b1000, 1'b0, 2'b00};
    dec[8]  = '{2'b10, 6'b001000, 4'b0001, 1'b1, 2'b00};
    dec[9]  = '{2'b00, 6'b001000, 4'b0010, 1'b0, 2'b00};
    dec[10] = '{2'b01, 6'b100000, 4'b0110, 1'b0, 2'b00};
    dec[11] = '{2'b11, 6'b100101, 4'b0000, 1'b0, 2'b00};
    dec[12] = '{2'b10, 6'b010000, 4'b0000, 1'b0, 2'b01};
    dec[13] = '{2'b10, 6'b010010, 4'b0000, 1'b0, 2'b10};
    dec[14] = '{2'b10, 6'b111111, 4'b0000, 1'b0, 2'b00};
    dec[15] = '{2'b10, 6'b100011, 4'b0110, 1'b0, 2'b00};

    rst_n = 1'b0; i_alu_op = 2'b00; i_funct = 6'd0; i_ex_valid = 1'b0; i_flush = 1'b0;
    #2;
    chk("reset_regs", {o_md_start, o_md_is_div, o_md_signed, o_md_busy, o_hilo_we, o_stall}, 6'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      i_alu_op = dec[i].op; i_funct = dec[i].fn;
      #1;
      chk($sformatf("decode[%0d]", i), {o_alu_ctrl, o_jr, o_hilo_rd}, {dec[i].ctrl, dec[i].jr, dec[i].hrd});
    end

    // mult: start at +1, busy +1..+4, hilo_we at +4
    tick();
    i_alu_op = 2'b10; i_funct = 6'b011000; i_ex_valid = 1'b1;
    hq.push_back(cyc + 4); sq.push_back('{32'(cyc + 1), 1'b0, 1'b1});
    @(negedge clk);
    chk("mult_accept_nostall", {o_stall, o_md_busy}, 2'b00);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) i_ex_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("mult_c%0d", c), {o_md_busy, o_hilo_we, o_md_start},
          {c <= 4, c == 4, c == 1});
      if (c == 1) chk("mult_flags", {o_md_is_div, o_md_signed}, 2'b01);
    end

    // divu followed by mflo held in EX; an add slips through mid-operation
    tick();
    i_funct = 6'b011011; i_ex_valid = 1'b1;
    hq.push_back(cyc + 32); sq.push_back('{32'(cyc + 1), 1'b1, 1'b0});
    for (int c = 1; c <= 33; c++) begin
      tick();
      i_funct = (c == 10) ? 6'b100000 : 6'b010010;
      @(negedge clk);
      chk($sformatf("divu_c%0d", c), {o_stall, o_hilo_we}, {(c <= 32) && (c != 10), c == 32});
    end
    chk("mflo_after_div", {o_hilo_rd, o_md_busy}, {2'b10, 1'b0});
    tick();
    i_ex_valid = 1'b0;

    // multu then div held in EX; div accepted the cycle after hilo_we, then flushed
    tick();
    i_funct = 6'b011001; i_ex_valid = 1'b1;
    hq.push_back(cyc + 4); sq.push_back('{32'(cyc + 1), 1'b0, 1'b0});
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) i_funct = 6'b011010;
      if (c == 5) begin
        hq.push_back(cyc + 32); sq.push_back('{32'(cyc + 1), 1'b1, 1'b1});
      end
      if (c == 6) i_ex_valid = 1'b0;
      if (c == 7) begin
        i_flush = 1'b1;
        hq.delete();
      end
      if (c == 8) i_flush = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b_c%0d", c), {o_stall, o_hilo_we, o_md_busy},
          {c <= 4, c == 4, (c <= 4) || (c == 6) || (c == 7)});
      if (c == 6) chk("div_start", {o_md_start, o_md_is_div, o_md_signed}, 3'b111);
    end
    repeat (40) tick();

    // flush in the accept cycle suppresses the accept
    i_funct = 6'b011010; i_ex_valid = 1'b1; i_flush = 1'b1;
    tick();
    i_ex_valid = 1'b0; i_flush = 1'b0;
    @(negedge clk);
    chk("flush_on_accept", {o_md_start, o_md_busy}, 2'b00);

    // asynchronous reset two cycles into a mult
    tick();
    i_funct = 6'b011000; i_ex_valid = 1'b1;
    hq.push_back(cyc + 4); sq.push_back('{32'(cyc + 1), 1'b0, 1'b1});
    tick();
    i_ex_valid = 1'b0;
    tick();
    i_ex_valid = 1'b1; i_funct = 6'b010000;
    rst_n = 1'b0;
    hq.delete();
    #1;
    chk("reset_mid_op", {o_md_start, o_md_is_div, o_md_signed, o_md_busy, o_hilo_we, o_stall}, 6'b0);
    i_alu_op = 2'b01;
    #1;
    chk("decode_in_reset", {o_alu_ctrl, o_hilo_rd}, {4'b0110, 2'b00});
    i_alu_op = 2'b10;
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("post_reset_%0d", c), {o_stall, o_hilo_we, o_md_busy}, 3'b000);
      tick();
    end
    i_ex_valid = 1'b0;

    chk("sb_queues_empty", {32'(hq.size()), 32'(sq.size())}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
